// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding,
// framing constants and the word-index to byte-address helper.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  // Frame header is a 16-bit big-endian word count.
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // Instruction memory is word-organised; the CPU sees byte addresses.
  function automatic logic [31:0] word_byte_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in and instruction-memory write port out. The master side is
// the byte source / memory observer, the slave side is the loader.
interface prog_loader_if;

  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output s_data, s_valid,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words. The three leading bytes of a
// word are held in a shift register; the fourth byte completes the word,
// which is captured in the write register and strobed out for one cycle.
module prog_loader_word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [BYTE_IDX_W-1:0] byte_cnt;
  logic [23:0]           shift;

  // High on the accept edge of the last byte of a word.
  assign word_done = byte_en && (byte_cnt == LAST_BYTE);

  // Track byte position within the word and keep the leading bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      shift    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shift    <= '0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 1'b1;
      shift    <= {shift[15:0], byte_in};
    end
  end

  // Load the finished word and raise the one-cycle write strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= word_done;
      if (word_done) begin
        word <= {shift, byte_in};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader. Receives a framed image (16-bit word count,
// big-endian words, XOR checksum), writes each word into instruction memory
// and releases the CPU only once a complete, verified image is in place.
// MAX_WORDS must not exceed 2**ADDR_W.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  prog_loader_if.slave     bus,
  output logic             cpu_run,
  output logic             busy,
  output logic             error,
  output logic [ADDR_W:0]  words_loaded
);

  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [15:0]     MAX_LEN = 16'(MAX_WORDS);

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               enter_hdr;
  logic [7:0]         len_hi;
  logic [15:0]        len_word;
  logic [CNT_W-1:0]   n_words;
  logic [CNT_W-1:0]   words_rx;
  logic               last_word;
  logic [7:0]         csum;
  logic               word_done;
  logic               word_valid;
  logic [31:0]        word;

  assign bus.s_ready = state inside {LEN_HI, LEN_LO, DATA, CHK};
  assign busy        = state inside {LEN_HI, LEN_LO, DATA, CHK};
  assign accept      = bus.s_valid && bus.s_ready;
  // start is honoured only between sessions; while busy it is ignored.
  assign enter_hdr   = start && (state inside {IDLE, DONE, ERR});
  assign len_word    = {len_hi, bus.s_data};
  assign last_word   = (words_rx + CNT_W'(1)) == n_words;

  prog_loader_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (enter_hdr),
    .byte_en    (accept && (state == DATA)),
    .byte_in    (bus.s_data),
    .word_done  (word_done),
    .word_valid (word_valid),
    .word       (word)
  );

  assign bus.imem_we    = word_valid;
  assign bus.imem_wdata = word;
  assign bus.imem_addr  = word_byte_addr(30'(words_loaded[ADDR_W-1:0]));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: flops are written with <= so every register samples the values
    // from before the edge, independent of block or statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode from the current state and the accepted byte.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is
    // inferred for the hold cases.
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = LEN_HI;
      LEN_HI: if (accept) state_next = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_word > MAX_LEN)   state_next = ERR;
          else if (len_word == '0)  state_next = CHK;
          else                      state_next = DATA;
        end
      end
      DATA:   if (word_done && last_word) state_next = CHK;
      CHK:    if (accept) state_next = (bus.s_data == csum) ? DONE : ERR;
      DONE,
      ERR:    if (start) state_next = LEN_HI;
      default: state_next = IDLE;
    endcase
  end

  // Header capture and count of words received in this session.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_hi   <= '0;
      n_words  <= '0;
      words_rx <= '0;
    end else if (enter_hdr) begin
      words_rx <= '0;
    end else begin
      if (accept && state == LEN_HI) len_hi <= bus.s_data;
      // Oversize lengths go to ERR, so the truncated value is never used.
      if (accept && state == LEN_LO) n_words <= CNT_W'(len_word);
      if (word_done) words_rx <= words_rx + CNT_W'(1);
    end
  end

  // Running XOR over header and data bytes; the checksum byte is excluded.
  always_ff @(posedge clk) begin
    if (!rst_n)                           csum <= '0;
    else if (enter_hdr)                   csum <= '0;
    else if (accept && state != CHK)      csum <= csum ^ bus.s_data;
  end

  // Words written this session; doubles as the memory word index.
  always_ff @(posedge clk) begin
    if (!rst_n)          words_loaded <= '0;
    else if (enter_hdr)  words_loaded <= '0;
    else if (word_valid) words_loaded <= words_loaded + CNT_W'(1);
  end

  // Status flags registered from the next state so they track DONE/ERR
  // exactly and drop on the edge that starts a reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_run <= 1'b0;
      error   <= 1'b0;
    end else begin
      cpu_run <= (state_next == DONE);
      error   <= (state_next == ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames from the test plan plus random
// images, with a scoreboard of expected memory writes checked by a monitor.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            cpu_run;
  logic            busy;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  prog_loader_if bus();

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", bus.imem_addr, e.addr);
        check("write_data", bus.imem_wdata, e.data);
      end
    end
  end

  // Reference model: interpret stim as a frame, queue the writes it implies,
  // and report the outcome and how many bytes the loader will take.
  task automatic model(output bit exp_ok, output int n_send, output int exp_words);
    int         n;
    logic [7:0] x;
    wr_t        e;
    n = int'({stim[0], stim[1]});
    if (n > MAX_WORDS) begin
      exp_ok    = 1'b0;
      n_send    = HDR_BYTES;
      exp_words = 0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < HDR_BYTES + BYTES_PER_WORD * n; i++) x ^= stim[i];
    for (int w = 0; w < n; w++) begin
      e.addr = 32'(4 * w);
      e.data = {stim[HDR_BYTES + 4*w], stim[HDR_BYTES + 4*w + 1],
                stim[HDR_BYTES + 4*w + 2], stim[HDR_BYTES + 4*w + 3]};
      exp_q.push_back(e);
    end
    n_send    = HDR_BYTES + BYTES_PER_WORD * n + 1;
    exp_ok    = (stim[n_send-1] == x);
    exp_words = n;
  endtask

  task automatic build_image(input int n, input bit corrupt);
    logic [7:0] x;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
    x = 8'h00;
    foreach (stim[i]) x ^= stim[i];
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    stim.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte until it transfers; bounded so a stuck s_ready fails.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit rdy;
    ok          = 1'b0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.s_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: byte 0x%0h not accepted in 50 cycles, want accepted", b);
    end
  endtask

  task automatic check_end(input string tag, input bit exp_ok, input int exp_words);
    check({tag, "_busy"},         32'(busy),         32'(0));
    check({tag, "_cpu_run"},      32'(cpu_run),      32'(exp_ok));
    check({tag, "_error"},        32'(error),        32'(!exp_ok));
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_words));
    check({tag, "_s_ready"},      32'(bus.s_ready),  32'(0));
    check({tag, "_pending"},      32'(exp_q.size()), 32'(0));
  endtask

  // gap_mode: 0 full rate, 1 alternate cycles, 2 random gaps.
  // start_at: byte index at which start is also raised (-1 for none).
  // overlap: raise start together with the first byte.
  task automatic run_session(input int gap_mode, input int start_at,
                             input bit overlap, input string tag);
    bit ok, sent, exp_ok;
    int n_send, exp_words;
    model(exp_ok, n_send, exp_words);
    if (overlap) start = 1'b1;
    else         pulse_start();
    sent = 1'b1;
    for (int i = 0; i < n_send && sent; i++) begin
      if (i > 0 && gap_mode == 1) idle(1);
      if (i > 0 && gap_mode == 2) idle(int'($urandom_range(0, 2)));
      if (i == start_at) start = 1'b1;
      send_byte(stim[i], ok);
      if (!ok) sent = 1'b0;
    end
    @(negedge clk);
    check_end(tag, exp_ok, exp_words);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, exp_ok;
    int n_send, exp_words;

    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",         32'(busy),         32'(0));
    check("rst_cpu_run",      32'(cpu_run),      32'(0));
    check("rst_error",        32'(error),        32'(0));
    check("rst_words_loaded", 32'(words_loaded), 32'(0));
    check("rst_s_ready",      32'(bus.s_ready),  32'(0));
    check("rst_imem_we",      32'(bus.imem_we),  32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Good two-word image.
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
    run_session(0, -1, 1'b0, "good");

    // Empty image, with start raised alongside the first byte.
    stim = {8'h00, 8'h00, 8'h00};
    run_session(0, -1, 1'b1, "empty");

    // Oversize length: ERR right after the second header byte.
    stim = {8'h01, 8'h01};
    run_session(0, -1, 1'b0, "oversize");

    // Bad checksum: both words still written.
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h20, 8'h09, 8'h00, 8'h0A, 8'h0D};
    run_session(0, -1, 1'b0, "bad_csum");

    // Alternate-cycle gaps with a stray start mid-load.
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
    run_session(1, 4, 1'b0, "gaps");

    // Largest accepted image.
    build_image(MAX_WORDS, 1'b0);
    run_session(0, -1, 1'b0, "max_len");

    // Random images, some with corrupted checksums, random gaps.
    for (int r = 0; r < 8; r++) begin
      build_image(int'($urandom_range(1, 6)), $urandom_range(0, 3) == 0);
      run_session(2, -1, 1'b0, "random");
    end

    // Reset on the edge that completes the first word: that write is dropped.
    stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};
    model(exp_ok, n_send, exp_words);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(stim[i], ok);
    bus.s_data  = stim[5];
    bus.s_valid = 1'b1;
    rst_n       = 1'b0;
    @(posedge clk); #1;
    rst_n       = 1'b1;
    bus.s_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_busy",         32'(busy),         32'(0));
    check("mid_rst_cpu_run",      32'(cpu_run),      32'(0));
    check("mid_rst_error",        32'(error),        32'(0));
    check("mid_rst_words_loaded", 32'(words_loaded), 32'(0));
    check("mid_rst_s_ready",      32'(bus.s_ready),  32'(0));
    check("mid_rst_imem_we",      32'(bus.imem_we),  32'(0));
    idle(3);
    check("mid_rst_pending", 32'(exp_q.size()), 32'(0));

    // Full good image after the reset.
    run_session(0, -1, 1'b0, "after_rst");

    // Reload from DONE: cpu_run drops on the start edge.
    pulse_start();
    @(negedge clk);
    check("reload_cpu_run",      32'(cpu_run),      32'(0));
    check("reload_busy",         32'(busy),         32'(1));
    check("reload_words_loaded", 32'(words_loaded), 32'(0));
    check("reload_error",        32'(error),        32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader directly upstream of the single-cycle CPU's instruction memory.
- Receives a framed byte stream (length header, big-endian instruction words, XOR checksum) over a valid/ready handshake.
- Writes each assembled word into instruction memory.
- Holds the CPU in reset (cpu_run low) until a complete, checksum-verified image has been written.

Parameters:
- ADDR_W, 8, word-index width of instruction memory (2^ADDR_W words)
- MAX_WORDS, 256, largest accepted image length in words (must be <= 2^ADDR_W)

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse, begins a load session
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader can accept a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  32  byte address, {word_idx, 2'b00}, upper bits zero
- imem_wdata  out  32  instruction word
- cpu_run  out  1  high = release CPU reset (drives CPU rst_n)
- busy  out  1  load session in progress
- error  out  1  last session failed
- words_loaded  out  ADDR_W+1  words written in current/last session

Behaviour:
- Reset: rst_n sampled low at a clk edge puts the FSM in IDLE and clears all outputs, counters, the XOR accumulator and the write register. Applies mid-session: any pending write is dropped.
- FSM states:
  - IDLE: start -> LEN_HI.
  - LEN_HI: accept byte -> LEN_LO.
  - LEN_LO: accept byte; N = {hi, lo}.
    - N > MAX_WORDS -> ERR.
    - N == 0 -> CHK.
    - Otherwise -> DATA.
  - DATA: accept bytes; after 4*N bytes -> CHK.
  - CHK: accept byte; byte == XOR accumulator -> DONE, else -> ERR.
  - DONE / ERR: start -> LEN_HI; otherwise hold.
- Handshake:
  - A byte transfers on an edge where s_valid && s_ready.
  - s_ready = 1 only in LEN_HI, LEN_LO, DATA and CHK (decoded from the state register).
  - Idle cycles between bytes are allowed without limit.
- Word assembly:
  - Big-endian; the first data byte is bits [31:24]. A 2-bit byte counter wraps 3 -> 0.
  - On the edge accepting byte 3 of a word, the write register is loaded. In the following cycle imem_we = 1 for exactly one cycle, with imem_addr = 4*word_idx and imem_wdata = the word.
  - word_idx starts at 0 and increments after each write.
  - Streaming continues during the write cycle, so back-to-back words at full rate are supported.
  - The final word's write cycle may coincide with the CHK byte acceptance.
- Checksum:
  - XOR of every accepted byte from LEN_HI through the last data byte.
  - The accumulator is cleared on entry to LEN_HI.
- words_loaded:
  - Cleared on entry to LEN_HI.
  - Increments with each imem_we.
  - Holds its value in DONE and ERR.
- busy: 1 in LEN_HI through CHK.
- error:
  - Set on entry to ERR.
  - Cleared on start or reset.
- cpu_run:
  - Registered; rises in the first cycle in DONE.
  - Drops on the same edge that takes start from DONE to LEN_HI, so a reload always re-holds the CPU in reset.
  - Never high in any other state.
- Simultaneous events:
  - start while busy is ignored.
  - start and s_valid together in IDLE: the byte is not consumed that cycle (s_ready = 0 in IDLE).
- Words written before an ERR stay in memory. The CPU stays held.

Decomposition:
- Shared package (cpu_defs alongside the existing defines):
  - FSM state encoding: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
  - Header length of 2 bytes.
  - Bytes-per-word value of 4.
- One natural sub-module: word_assembler. It contains the byte counter, 32-bit shift register and write register. It emits a one-cycle word_valid strobe with the word.

Test Plan:
- Good image: start, then bytes 00 02 20 08 00 05 20 09 00 0A 0C -> two writes (addr 0x0, data 0x20080005; addr 0x4, data 0x2009000A); DONE; cpu_run = 1; words_loaded = 2; error = 0.
- Empty image: bytes 00 00 00 -> DONE with no imem_we; cpu_run = 1; words_loaded = 0.
- Oversize length: bytes 01 01 (N = 257) -> ERR right after the second byte; s_ready = 0; error = 1; cpu_run = 0; no writes.
- Bad checksum: the good image with a final byte of 0D -> both writes issued, then ERR; cpu_run = 0; error = 1.
- Backpressure/gaps: the good image with s_valid low on alternate cycles, plus start pulsed mid-load -> identical writes and result; start ignored.
- Reset mid-load: rst_n low after 5 bytes of the good image -> next cycle IDLE, all outputs 0, no further imem_we. A following start plus the full good image -> DONE. A second start from DONE -> cpu_run drops on that edge.
